// File: rtl/quant_seq_if.sv
// Bus bundle between the quantizer sequencer and its surroundings.
//  master : the sequencer (drives addresses, quantizer operands, write port, status)
//  slave  : the environment (coefficient buffer, Q-table RAM, quantizer, output buffer, control)
// Optional: QUANT_NZCNT_EN adds nz_cnt_o (nonzero-lane count of the written block).
interface quant_seq_if #(
  parameter int unsigned AW = 5
);
  logic          start_i;
  logic          busy_o;
  logic          done_o;
  logic [AW-1:0] cb_addr_o;
  logic [31:0]   cb_data_i;
  logic [AW-1:0] qt_addr_o;
  logic [31:0]   qt_data_i;
  logic [31:0]   qx_o;
  logic [31:0]   qrec_o;
  logic [31:0]   qres_i;
  logic          ob_we_o;
  logic [AW-1:0] ob_addr_o;
  logic [31:0]   ob_data_o;
`ifdef QUANT_NZCNT_EN
  logic [6:0]    nz_cnt_o;
`endif

  modport master (
`ifdef QUANT_NZCNT_EN
    output nz_cnt_o,
`endif
    input  start_i, cb_data_i, qt_data_i, qres_i,
    output busy_o, done_o, cb_addr_o, qt_addr_o, qx_o, qrec_o,
    output ob_we_o, ob_addr_o, ob_data_o
  );

  modport slave (
`ifdef QUANT_NZCNT_EN
    input  nz_cnt_o,
`endif
    output start_i, cb_data_i, qt_data_i, qres_i,
    input  busy_o, done_o, cb_addr_o, qt_addr_o, qx_o, qrec_o,
    input  ob_we_o, ob_addr_o, ob_data_o
  );
endinterface

// File: rtl/quant_seq.sv
// Sequencer for the packed dual-lane quantizer datapath.
// On an accepted start it streams one block of NWORDS packed coefficient words and the
// matching reciprocal words into the quantizer, writes each result to the output buffer,
// and pulses done_o once the block is fully written.
// Ports:
//  clk_i  : system clock
//  rst_ni : asynchronous active-low reset
//  bus    : quant_seq_if.master (start/busy/done, coeff + Q-table reads, quantizer operands,
//           output buffer write port)
// Optional: QUANT_NZCNT_EN adds bus.nz_cnt_o, the count of nonzero 16b lanes written.
module quant_seq #(
  parameter int unsigned NWORDS = 32,
  parameter int unsigned AW     = 5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  quant_seq_if.master bus
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic          start_acc;
  logic          rd_last;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic          wr_valid;

  assign rd_last = (rd_addr == LAST_ADDR);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; start is only honoured from IDLE
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start_i) begin
          state_nxt = RUN;
          start_acc = 1'b1;
        end
      end
      RUN:     if (rd_last) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read address counter plus one-cycle delayed write address/valid matching the RAM latency
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_addr  <= '0;
      wr_addr  <= '0;
      wr_valid <= 1'b0;
    end else begin
      if (start_acc)                      rd_addr <= '0;
      else if (state == RUN && !rd_last)  rd_addr <= rd_addr + AW'(1);
      wr_addr  <= rd_addr;
      wr_valid <= (state == RUN);
    end
  end

  assign bus.busy_o    = (state != IDLE);
  assign bus.done_o    = (state == DONE);
  assign bus.cb_addr_o = rd_addr;
  assign bus.qt_addr_o = rd_addr;
  assign bus.qx_o      = wr_valid ? bus.cb_data_i : 32'h0;
  assign bus.qrec_o    = wr_valid ? bus.qt_data_i : 32'h0;
  assign bus.ob_we_o   = wr_valid;
  assign bus.ob_addr_o = wr_addr;
  assign bus.ob_data_o = bus.qres_i;

`ifdef QUANT_NZCNT_EN
  logic [6:0] nz_cnt;
  logic [1:0] nz_inc;

  assign nz_inc = {1'b0, |bus.qres_i[31:16]} + {1'b0, |bus.qres_i[15:0]};

  // Nonzero lane count for the block being written; holds after done until the next start
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       nz_cnt <= '0;
    else if (start_acc) nz_cnt <= '0;
    else if (wr_valid)  nz_cnt <= nz_cnt + 7'(nz_inc);
  end

  assign bus.nz_cnt_o = nz_cnt;
`endif

endmodule

// File: tb/tb_quant_seq.sv
// Scoreboard bench for quant_seq: stimulus pushes expected writes into a queue at start
// acceptance; a negedge monitor pops and compares on each output-buffer write and checks
// busy/write/done timing against the cycle of acceptance.
module tb_quant_seq;

  localparam int unsigned NW = 32;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] cb_mem [NW];
  logic [31:0] qt_mem [NW];

  wr_t exp_q[$];
  bit  have_blk = 1'b0;
  int  blk_a = 0;
  int  exp_nz = 0;

  quant_seq_if #(.AW(5)) bus ();

  quant_seq #(.NWORDS(NW), .AW(5)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Quantizer stand-in: per lane signed x * rec, rounded, arithmetic shift by 17
  function automatic logic [15:0] qlane(logic [15:0] x, logic [15:0] r);
    int p;
    p = int'($signed(x)) * int'($signed(r));
    return 16'((p + 65536) >>> 17);
  endfunction

  function automatic logic [31:0] qword(logic [31:0] x, logic [31:0] r);
    return {qlane(x[31:16], r[31:16]), qlane(x[15:0], r[15:0])};
  endfunction

  assign bus.qres_i = qword(bus.qx_o, bus.qrec_o);

  // Registered-read coefficient buffer and Q-table
  always @(posedge clk) begin
    bus.cb_data_i <= cb_mem[bus.cb_addr_o];
    bus.qt_data_i <= qt_mem[bus.qt_addr_o];
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    bit exp_busy, exp_we, exp_done;
    wr_t e;
    if (!rst_n) begin
      chk("rst_busy", 32'(bus.busy_o), 0);
      chk("rst_done", 32'(bus.done_o), 0);
      chk("rst_we", 32'(bus.ob_we_o), 0);
      chk("rst_cb_addr", 32'(bus.cb_addr_o), 0);
      chk("rst_ob_addr", 32'(bus.ob_addr_o), 0);
      chk("rst_qx", bus.qx_o, 0);
      chk("rst_qrec", bus.qrec_o, 0);
    end else begin
      exp_busy = have_blk && cyc >= blk_a && cyc <= blk_a + 33;
      exp_we   = have_blk && cyc >= blk_a + 1 && cyc <= blk_a + 32;
      exp_done = have_blk && cyc == blk_a + 33;
      chk("busy", 32'(bus.busy_o), 32'(exp_busy));
      chk("ob_we", 32'(bus.ob_we_o), 32'(exp_we));
      chk("done", 32'(bus.done_o), 32'(exp_done));
      if (have_blk && cyc >= blk_a && cyc <= blk_a + 31) begin
        chk("cb_addr", 32'(bus.cb_addr_o), 32'(cyc - blk_a));
        chk("qt_addr", 32'(bus.qt_addr_o), 32'(cyc - blk_a));
      end
      if (bus.ob_we_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(bus.ob_addr_o), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("ob_addr", 32'(bus.ob_addr_o), 32'(e.addr));
          chk("ob_data", bus.ob_data_o, e.data);
        end
      end
`ifdef QUANT_NZCNT_EN
      if (exp_done) chk("nz_cnt", 32'(bus.nz_cnt_o), 32'(exp_nz));
`endif
    end
  end

  // All tasks begin and end 1 time unit after a rising edge
  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    int a;
    wr_t e;
    a = cyc + 1;
    bus.start_i = 1'b1;
    if (!have_blk || a >= blk_a + 35) begin
      have_blk = 1'b1;
      blk_a = a;
      exp_nz = 0;
      for (int k = 0; k < int'(NW); k++) begin
        e.addr = 5'(k);
        e.data = qword(cb_mem[k], qt_mem[k]);
        exp_nz += int'(e.data[31:16] != 16'h0) + int'(e.data[15:0] != 16'h0);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  task automatic fill_random();
    logic [15:0] a, b;
    for (int k = 0; k < int'(NW); k++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(3) == 0) a = 16'h0;
      if ($urandom_range(3) == 0) b = 16'h0;
      cb_mem[k] = {a, b};
      qt_mem[k] = {16'($urandom_range(32767)), 16'($urandom_range(32767))};
    end
  endtask

  initial begin
    bus.start_i = 1'b0;
    for (int k = 0; k < int'(NW); k++) begin
      cb_mem[k] = {16'(k), 16'(-k)};
      qt_mem[k] = 32'h4000_4000;
    end
    idle(3);
    rst_n = 1'b1;
    idle(3);

    // Directed ramp block
    pulse_start();
    idle(40);

    // Starts during the run are ignored
    fill_random();
    pulse_start();
    idle(3);
    pulse_start();
    idle(14);
    pulse_start();
    idle(30);

    // Back-to-back at the minimum spacing
    fill_random();
    pulse_start();
    idle(34);
    pulse_start();
    idle(40);

    // Reset in the middle of a block, then a clean block
    fill_random();
    pulse_start();
    idle(11);
    rst_n = 1'b0;
    have_blk = 1'b0;
    exp_q.delete();
    idle(2);
    rst_n = 1'b1;
    idle(3);
    pulse_start();
    idle(40);

    // Sparse block: only first and last word nonzero
    for (int k = 0; k < int'(NW); k++) begin
      cb_mem[k] = 32'h0;
      qt_mem[k] = 32'h7FFF_7FFF;
    end
    cb_mem[0] = 32'h7FFF_7FFF;
    cb_mem[NW-1] = 32'h7FFF_7FFF;
    pulse_start();
    idle(40);

    // Random blocks
    for (int b = 0; b < 3; b++) begin
      fill_random();
      pulse_start();
      idle(34 + $urandom_range(3));
    end
    idle(5);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
